// File: rtl/muldiv.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide on magnitudes, sign fixup in FIX.
module muldiv #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = $clog2(N) + 1;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      op_q, op_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [2*N-1:0]  p_q, p_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;
  logic [N-1:0]    hi_q, hi_d;
  logic [N-1:0]    lo_q, lo_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            accept;
  logic            sgn_in;
  logic            a_neg;
  logic            b_neg;
  logic [N-1:0]    a_mag;
  logic [N-1:0]    b_mag;
  logic [N:0]      mul_sum;
  logic [N:0]      rem_sh;
  logic            ge;
  logic [N-1:0]    rem_new;
  logic            sgn_q;
  logic [2*N-1:0]  prod;
  logic [N-1:0]    quo;
  logic [N-1:0]    rem;

  always_comb begin
    accept  = start && (state_q == IDLE || state_q == DONE);
    sgn_in  = ~op[0];
    a_neg   = sgn_in & a[N-1];
    b_neg   = sgn_in & b[N-1];
    a_mag   = a_neg ? -a : a;
    b_mag   = b_neg ? -b : b;

    // Multiply: add multiplicand into upper half when LSB set, then shift.
    mul_sum = {1'b0, p_q[2*N-1:N]} + (p_q[0] ? {1'b0, b_q} : '0);

    // Restoring divide: remainder in upper half, quotient shifts into lower.
    rem_sh  = {p_q[2*N-1:N], p_q[N-1]};
    ge      = rem_sh >= {1'b0, b_q};
    rem_new = ge ? (rem_sh[N-1:0] - b_q) : rem_sh[N-1:0];

    sgn_q   = ~op_q[0];
    prod    = (sgn_q && neg_q) ? -p_q : p_q;
    quo     = (sgn_q && neg_q) ? -p_q[N-1:0] : p_q[N-1:0];
    rem     = (sgn_q && rneg_q) ? -p_q[2*N-1:N] : p_q[2*N-1:N];

    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          unique case (1'b1)
            !op[2]: begin
              state_d = CALC;
              cnt_d   = '0;
              op_d    = op[1:0];
              a_d     = a;
              b_d     = b_mag;
              p_d     = {{N{1'b0}}, a_mag};
              neg_d   = a_neg ^ b_neg;
              rneg_d  = a_neg;
            end
            op == OP_MTHI: hi_d = a;
            op == OP_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q[1]) p_d = {rem_new, p_q[N-2:0], ge};
        else         p_d = {mul_sum, p_q[N-1:1]};
        if (cnt_q == CW'(N - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = DONE;
        if (!op_q[1]) begin
          hi_d = prod[2*N-1:N];
          lo_d = prod[N-1:0];
        end else if (b_q == '0) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// Scoreboard bench for muldiv: directed vectors, expected HI/LO and done cycle
// queued at issue time and checked by an independent done monitor.
module tb_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv #(.N(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] h;
    logic [31:0] l;
    int          c;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   nvec = 0;
  int   nbad = 0;
  int   c0 = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        nvec++;
        nbad++;
        $display("FAIL spurious_done: got done at cycle %0d want none", cyc);
      end else begin
        me = sb.pop_front();
        chk("hi", hi, me.h);
        chk("lo", lo, me.l);
        chk("done_cycle", 32'(cyc), 32'(me.c));
      end
    end
  end

  // Called mid-cycle; the next rising edge is the acceptance edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] eh,
                       input logic [31:0] el);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    c0    = cyc;
    sb.push_back('{eh, el, cyc + 34});
    @(negedge clk);
    #1;
    start = 1'b0;
    a     = 32'hA5A5_A5A5;
    b     = 32'h5A5A_5A5A;
  endtask

  task automatic wait_done(input string nm);
    bit bok;
    bok = 1'b1;
    while (sb.size() != 0 && cyc < c0 + 45) begin
      if (busy !== 1'b1) bok = 1'b0;
      @(negedge clk);
      #1;
    end
    nvec++;
    if (sb.size() != 0) begin
      nbad++;
      $display("FAIL %s_timeout: got no done by cycle %0d want done", nm, cyc);
      sb.delete();
    end
    chk({nm, "_busy"}, 32'(bok), 32'd1);
    chk({nm, "_busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    rst_n = 1'b1;
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    wait_done("multu_max");
    issue(3'b000, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    wait_done("mult_neg");
    issue(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_done("div_neg");
    @(negedge clk);
    #1;
    issue(3'b011, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
    wait_done("divu_zero");
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    wait_done("div_ovf");
    issue(3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    wait_done("div_negdiv");
    issue(3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    wait_done("mult_min");
    issue(3'b011, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF);
    wait_done("divu_big");
    issue(3'b010, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF);
    wait_done("div_zero");

    @(negedge clk);
    #1;
    issue(3'b001, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 32'h0000_000C);
    while (cyc < c0 + 10) begin
      @(negedge clk);
      #1;
    end
    start = 1'b1;
    op    = 3'b011;
    a     = 32'd100;
    b     = 32'd7;
    @(negedge clk);
    #1;
    start = 1'b0;
    wait_done("start_ignored");

    start = 1'b1;
    op    = 3'b110;
    a     = 32'hFFFF_0000;
    @(negedge clk);
    #1;
    start = 1'b0;
    chk("rsvd_hi", hi, 32'h0);
    chk("rsvd_lo", lo, 32'h0000_000C);
    chk("rsvd_busy", 32'(busy), 32'd0);

    start = 1'b1;
    op    = 3'b100;
    a     = 32'h1234_5678;
    @(negedge clk);
    #1;
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_lo", lo, 32'h0000_000C);
    chk("mthi_busy", 32'(busy), 32'd0);
    op = 3'b101;
    a  = 32'h9ABC_DEF0;
    @(negedge clk);
    #1;
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h9ABC_DEF0);
    chk("mtlo_hi", hi, 32'h1234_5678);
    repeat (3) @(negedge clk);
    #1;
    chk("mt_busy", 32'(busy), 32'd0);

    issue(3'b010, 32'd100, 32'd7, 32'd2, 32'd14);
    while (cyc < c0 + 15) begin
      @(negedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    sb.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    issue(3'b001, 32'h0000_0006, 32'h0000_0007, 32'h0000_0000, 32'h0000_002A);
    wait_done("after_reset");
    repeat (5) @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time %0t want finish", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv.md
MULDIV -- requirements
Module: muldiv

Interface
REQ-001 Parameter N, default 32: operand and HI/LO width.
REQ-002 Clocking and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request strobe; sampled on the rising edge of clk.
REQ-006 op  input  3  operation select: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are reserved.
REQ-007 a  input  N  operand A (multiplicand or dividend; source for MTHI/MTLO).
REQ-008 b  input  N  operand B (multiplier or divisor).
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse; hi and lo hold the new result in this cycle.
REQ-011 hi  output  N  HI register (product upper half or remainder).
REQ-012 lo  output  N  LO register (product lower half or quotient).

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, CALC, FIX and DONE.
REQ-014 Acceptance: start=1 SHALL be accepted only in IDLE or DONE; start in CALC or FIX is ignored with no state change.
REQ-015 On an accepted start, a and b SHALL be latched at the acceptance edge; later changes on a/b have no effect.
REQ-016 Accepted MULT/MULTU/DIV/DIVU: the FSM SHALL go to CALC, run exactly N iterations, then spend one cycle in FIX, then enter DONE.
REQ-017 Result write: hi and lo SHALL update only on the edge entering DONE.
REQ-018 Latency: done SHALL be high exactly N+2 cycles after the acceptance cycle (34 for N=32), for exactly one cycle.
REQ-019 FSM exit from DONE: DONE SHALL go to IDLE unless a new start is accepted in DONE.
REQ-020 Status outputs: busy=1 in CALC and FIX only; done=1 in DONE only.
REQ-021 Multiply: shift-add on operand magnitudes SHALL produce a 2N-bit product; {hi,lo} = full product.
REQ-022 Signed ops (MULT, DIV): FIX SHALL negate the result per the operand signs.
REQ-023 Divide: restoring division on magnitudes; lo=quotient truncated toward zero; hi=remainder with the sign of the dividend.
REQ-024 Divide by zero (b=0, DIV or DIVU): lo SHALL be all ones and hi=a, with the same latency.
REQ-025 Overflow case DIV a=2^(N-1), b=-1: lo=2^(N-1) and hi=0.
REQ-026 MTHI/MTLO: hi (resp. lo) SHALL be loaded from a on the acceptance edge; the FSM stays in or returns to IDLE; no busy; no done.
REQ-027 Reserved op codes with start=1 SHALL be ignored: no state, hi or lo change.
REQ-028 Between results, hi and lo SHALL hold their values; intermediate iteration state SHALL NOT be visible on hi/lo.

Reset
REQ-029 On rst_n=0 the block SHALL asynchronously enter IDLE with busy=0, done=0, hi=0, lo=0, and the iteration counter and internal datapath cleared.
REQ-030 Reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow reset release.
REQ-031 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-032 MULTU a=FFFFFFFF, b=FFFFFFFF -> done at cycle 34; hi=FFFFFFFE, lo=00000001; busy high in cycles 1-33.
REQ-033 MULT a=FFFFFFFD (-3), b=00000005 -> hi=FFFFFFFF, lo=FFFFFFF1; DIV a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-034 DIVU a=00000007, b=0 -> lo=FFFFFFFF, hi=00000007; DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000.
REQ-035 MULTU 3x4 started, start DIVU pulsed at cycle 10 -> ignored; done at cycle 34 with hi=0, lo=0000000C.
REQ-036 MTHI a=12345678 then MTLO a=9ABCDEF0 on consecutive cycles -> hi/lo updated on each acceptance edge; busy and done never assert.
REQ-037 rst_n pulsed low at cycle 15 of a DIV -> hi=lo=0 and busy=0 immediately; no done for 40 cycles; a new MULTU accepted on the first edge after release completes normally.
